// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multi-cycle CPU main controller.
// Sequences fetch/decode/execute/memory/writeback, drives the datapath
// enables and mux selects, waits on the memory ready handshake and counts
// retired instructions.
//
// state    | code | meaning
// ---------+------+------------------------------------------------------
// IDLE     |  0   | first cycle after reset, no datapath activity
// FETCH    |  1   | read instruction at PC, PC+4 on memory ready
// DECODE   |  2   | read registers, precompute branch target
// MEM_ADDR |  3   | effective address rs + imm for lw/sw
// MEM_RD   |  4   | data read at ALUOut, wait for memory ready
// MEM_WB   |  5   | write MDR into rt
// MEM_WR   |  6   | data write at ALUOut, wait for memory ready
// R_EXE    |  7   | R-type ALU operation selected by funct
// R_WB     |  8   | write ALUOut into rd
// BR       |  9   | beq compare, PC <= ALUOut when zero
// JMP      | 10   | PC <= jump target
// I_EXE    | 11   | addi/slti ALU operation with sign-extended imm
// I_WB     | 12   | write ALUOut into rt
// TRAP     | 13   | unsupported opcode, parked until reset
module mc_main_ctrl #(
    parameter int CNT_W = 16,
    parameter int OP_W  = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic [OP_W-1:0]  funct_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic             ir_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             iord_o,
    output logic             reg_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [1:0]       pc_src_o,
    output logic [3:0]       state_o,
    output logic             instr_done_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXE    = 4'd7,
        S_R_WB     = 4'd8,
        S_BR       = 4'd9,
        S_JMP      = 4'd10,
        S_I_EXE    = 4'd11,
        S_I_WB     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'h0A);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               illegal_q, illegal_d;

    // funct is decoded by the ALU control and zero gates the PC in the
    // datapath; both are visible here for debug only.
    logic               debug_unused;
    assign debug_unused = ^{funct_i, zero_i};

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_RTYPE:        state_d = S_R_EXE;
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ:          state_d = S_BR;
                    OP_J:            state_d = S_JMP;
                    OP_ADDI, OP_SLTI: state_d = S_I_EXE;
                    default:         state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready_i) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_ready_i) state_d = S_FETCH;
            S_R_EXE:    state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BR:       state_d = S_FETCH;
            S_JMP:      state_d = S_FETCH;
            S_I_EXE:    state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
    end

    // Control outputs from the registered state; only the FETCH/MEM_WR
    // handshake qualifies the load and done strobes with mem_ready_i.
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        ir_write_o      = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        iord_o          = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'd0;
        alu_op_o        = 2'd0;
        pc_src_o        = 2'd0;
        instr_done_o    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'd1;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_o = 2'd3;
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o  = 1'b1;
                iord_o       = 1'b1;
                instr_done_o = mem_ready_i;
            end
            S_R_EXE: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'd2;
            end
            S_R_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 1'b1;
                instr_done_o = 1'b1;
            end
            S_BR: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = 2'd1;
                pc_write_cond_o = 1'b1;
                pc_src_o        = 2'd1;
                instr_done_o    = 1'b1;
            end
            S_JMP: begin
                pc_write_o   = 1'b1;
                pc_src_o     = 2'd2;
                instr_done_o = 1'b1;
            end
            S_I_EXE: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_op_o    = (op_i == OP_SLTI) ? 2'd3 : 2'd0;
            end
            S_I_WB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Retired count and sticky illegal flag; illegal rises together with
    // the entry into TRAP so both are visible in the same cycle.
    always_comb begin
        retired_d = retired_q;
        illegal_d = illegal_q;
        if (instr_done_o) begin
            retired_d = retired_q + CNT_W'(1);
        end
        if (state_d == S_TRAP) begin
            illegal_d = 1'b1;
        end
    end

    // Status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign state_o   = state_q;
    assign illegal_o = illegal_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: the stimulus process pushes the
// hand-derived per-cycle response, the monitor pops and compares it at the
// falling edge of every cycle.
module tb_mc_main_ctrl;

    localparam int CNT_W = 2;
    localparam int OP_W  = 6;

    // Control word: {pc_write, pc_write_cond, ir_write, mem_read, mem_write,
    // iord, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0],
    // alu_op[1:0], pc_src[1:0], instr_done}
    localparam logic [16:0] C_NONE  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_FW    = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FR    = 17'b1_0_1_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DEC   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_MADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MRD   = 17'b0_0_0_1_0_1_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_1;
    localparam logic [16:0] C_MWRW  = 17'b0_0_0_0_1_1_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MWRR  = 17'b0_0_0_0_1_1_0_0_0_0_00_00_00_1;
    localparam logic [16:0] C_REXE  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_RWB   = 17'b0_0_0_0_0_0_1_1_0_0_00_00_00_1;
    localparam logic [16:0] C_BR    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_1;
    localparam logic [16:0] C_JMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_1;
    localparam logic [16:0] C_ADDI  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_SLTI  = 17'b0_0_0_0_0_0_0_0_0_1_10_11_00_0;
    localparam logic [16:0] C_IWB   = 17'b0_0_0_0_0_0_1_0_0_0_00_00_00_1;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                           OP_ADDI = 6'h08, OP_SLTI = 6'h0A,
                           OP_LW = 6'h23, OP_SW = 6'h2B, OP_BAD = 6'h3F;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [OP_W-1:0]  op_i;
    logic [OP_W-1:0]  funct_i;
    logic             zero_i;
    logic             mem_ready_i;
    logic             pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o;
    logic             mem_write_o, iord_o, reg_write_o, reg_dst_o;
    logic             mem_to_reg_o, alu_src_a_o, instr_done_o, illegal_o;
    logic [1:0]       alu_src_b_o, alu_op_o, pc_src_o;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] retired_o;

    typedef struct packed {
        logic [3:0]       st;
        logic [16:0]      ctl;
        logic [CNT_W-1:0] ret;
        logic             ill;
    } exp_t;

    exp_t             sb_q[$];
    logic [CNT_W-1:0] exp_ret;
    int               vectors = 0;
    int               miscompares = 0;

    mc_main_ctrl #(.CNT_W(CNT_W), .OP_W(OP_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct_i(funct_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
        .ir_write_o(ir_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .iord_o(iord_o),
        .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
        .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .pc_src_o(pc_src_o),
        .state_o(state_o), .instr_done_o(instr_done_o),
        .illegal_o(illegal_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    // One cycle of stimulus: drive inputs just after the rising edge and
    // record what the DUT must show until the next rising edge.
    task automatic step(input logic [5:0] op, input logic rdy, input logic rst,
                        input logic [3:0] st, input logic [16:0] ctl,
                        input logic ill);
        exp_t e;
        rst_i       = rst;
        op_i        = op;
        mem_ready_i = rdy;
        funct_i     = 6'h20;
        zero_i      = 1'b1;
        if (rst) exp_ret = '0;
        e.st  = st;
        e.ctl = ctl;
        e.ret = exp_ret;
        e.ill = ill;
        sb_q.push_back(e);
        if (ctl[0]) exp_ret = exp_ret + 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: compare the DUT against the oldest expected entry.
    always @(negedge clk_i) begin
        exp_t        e;
        logic [16:0] act;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o,
                   mem_write_o, iord_o, reg_write_o, reg_dst_o, mem_to_reg_o,
                   alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o, instr_done_o};
            vectors++;
            if (state_o !== e.st) begin
                miscompares++;
                $display("FAIL state vec %0d: got %0d want %0d", vectors, state_o, e.st);
            end
            if (act !== e.ctl) begin
                miscompares++;
                $display("FAIL ctrl vec %0d (state %0d): got %b want %b", vectors, e.st, act, e.ctl);
            end
            if (retired_o !== e.ret) begin
                miscompares++;
                $display("FAIL retired vec %0d: got %0d want %0d", vectors, retired_o, e.ret);
            end
            if (illegal_o !== e.ill) begin
                miscompares++;
                $display("FAIL illegal vec %0d: got %b want %b", vectors, illegal_o, e.ill);
            end
            if (mem_read_o === 1'b1 && mem_write_o === 1'b1) begin
                miscompares++;
                $display("FAIL rd_wr_excl vec %0d: got both 1 want at most one", vectors);
            end
        end
    end

    initial begin
        exp_ret     = '0;
        rst_i       = 1'b1;
        op_i        = '0;
        funct_i     = '0;
        zero_i      = 1'b0;
        mem_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        // reset, release, IDLE -> FETCH
        step(OP_R, 0, 1, 4'd0, C_NONE, 0);
        step(OP_R, 0, 0, 4'd0, C_NONE, 0);
        step(OP_R, 0, 0, 4'd1, C_FW,   0);
        step(OP_R, 0, 0, 4'd1, C_FW,   0);
        // reset in the middle of a FETCH wait takes effect at once
        step(OP_R, 0, 1, 4'd0, C_NONE, 0);
        step(OP_R, 0, 0, 4'd0, C_NONE, 0);
        // add
        step(OP_R, 1, 0, 4'd1, C_FR,   0);
        step(OP_R, 0, 0, 4'd2, C_DEC,  0);
        step(OP_R, 0, 0, 4'd7, C_REXE, 0);
        step(OP_R, 0, 0, 4'd8, C_RWB,  0);
        // lw with three wait cycles
        step(OP_LW, 1, 0, 4'd1, C_FR,   0);
        step(OP_LW, 0, 0, 4'd2, C_DEC,  0);
        step(OP_LW, 0, 0, 4'd3, C_MADR, 0);
        step(OP_LW, 0, 0, 4'd4, C_MRD,  0);
        step(OP_LW, 0, 0, 4'd4, C_MRD,  0);
        step(OP_LW, 0, 0, 4'd4, C_MRD,  0);
        step(OP_LW, 1, 0, 4'd4, C_MRD,  0);
        step(OP_LW, 0, 0, 4'd5, C_MWB,  0);
        // sw with one wait cycle
        step(OP_SW, 1, 0, 4'd1, C_FR,   0);
        step(OP_SW, 0, 0, 4'd2, C_DEC,  0);
        step(OP_SW, 0, 0, 4'd3, C_MADR, 0);
        step(OP_SW, 0, 0, 4'd6, C_MWRW, 0);
        step(OP_SW, 1, 0, 4'd6, C_MWRR, 0);
        // beq then j
        step(OP_BEQ, 1, 0, 4'd1,  C_FR,  0);
        step(OP_BEQ, 0, 0, 4'd2,  C_DEC, 0);
        step(OP_BEQ, 0, 0, 4'd9,  C_BR,  0);
        step(OP_J,   1, 0, 4'd1,  C_FR,  0);
        step(OP_J,   0, 0, 4'd2,  C_DEC, 0);
        step(OP_J,   0, 0, 4'd10, C_JMP, 0);
        // slti
        step(OP_SLTI, 1, 0, 4'd1,  C_FR,   0);
        step(OP_SLTI, 0, 0, 4'd2,  C_DEC,  0);
        step(OP_SLTI, 0, 0, 4'd11, C_SLTI, 0);
        step(OP_SLTI, 0, 0, 4'd12, C_IWB,  0);
        // reset during a MEM_RD wait clears state and count
        step(OP_LW, 1, 0, 4'd1, C_FR,   0);
        step(OP_LW, 0, 0, 4'd2, C_DEC,  0);
        step(OP_LW, 0, 0, 4'd3, C_MADR, 0);
        step(OP_LW, 0, 0, 4'd4, C_MRD,  0);
        step(OP_LW, 0, 1, 4'd0, C_NONE, 0);
        step(OP_LW, 0, 0, 4'd0, C_NONE, 0);
        // five addi: retired 1,2,3,0,1 with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            step(OP_ADDI, 1, 0, 4'd1,  C_FR,   0);
            step(OP_ADDI, 0, 0, 4'd2,  C_DEC,  0);
            step(OP_ADDI, 0, 0, 4'd11, C_ADDI, 0);
            step(OP_ADDI, 0, 0, 4'd12, C_IWB,  0);
        end
        // unsupported opcode parks in TRAP with illegal held
        step(OP_BAD, 1, 0, 4'd1,  C_FR,   0);
        step(OP_BAD, 0, 0, 4'd2,  C_DEC,  0);
        step(OP_BAD, 1, 0, 4'd13, C_NONE, 1);
        step(OP_R,   1, 0, 4'd13, C_NONE, 1);
        step(OP_R,   0, 0, 4'd13, C_NONE, 1);
        step(OP_R,   0, 1, 4'd0,  C_NONE, 0);
        step(OP_R,   0, 0, 4'd0,  C_NONE, 0);
        step(OP_R,   0, 0, 4'd1,  C_FW,   0);
        @(negedge clk_i);
        #1;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        if (vectors == 0) begin
            miscompares++;
            $display("FAIL vectors_seen: got 0 want nonzero");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
